// File: rtl/simplez_loader_if.sv
// Byte-in / memory-out signal bundle of the Simplez serial program loader.
// master = loader side, slave = UART receiver, memory and CPU side.
interface simplez_loader_if #(
   parameter int DATAW = 12,
   parameter int ADDRW = 9
);
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic [ADDRW-1:0] mem_addr;
   logic [DATAW-1:0] mem_data;
   logic             mem_wr;
   logic             cpu_rstn;
   logic             loading;
   logic             done;
   logic             error;

   modport master (
      input  rx_data, rx_valid,
      output mem_addr, mem_data, mem_wr, cpu_rstn, loading, done, error
   );
   modport slave (
      output rx_data, rx_valid,
      input  mem_addr, mem_data, mem_wr, cpu_rstn, loading, done, error
   );
endinterface

// File: rtl/simplez_loader.sv
// Simplez serial program loader: assembles UART bytes into words and writes memory from address 0.
// Define LOADER_CHECKSUM_EN to require a trailing 8-bit checksum byte after the words.
module simplez_loader #(
   parameter int         DATAW     = 12,
   parameter int         ADDRW     = 9,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input logic              clk,
   input logic              rst,
   simplez_loader_if.master bus
);
   localparam int          HIW     = DATAW - 8;
   localparam logic [16:0] MAX_LEN = 17'd1 << ADDRW;

   typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, W_HI, W_LO, CSUM, RUN, ERR} state_t;

   state_t           state, state_nxt;
   logic [7:0]       len_hi, hi_byte, csum;
   logic [15:0]      len, len_new;
   logic [ADDRW-1:0] cnt;
   logic [16:0]      cnt_inc;
   logic             last_word;
   logic [ADDRW-1:0] mem_addr_q;
   logic [DATAW-1:0] mem_data_q;
   logic             mem_wr_q, cpu_rstn_q, loading_q, done_q, error_q;
   logic             cpu_rstn_d, loading_d, done_d, error_d;

   assign len_new   = {len_hi, bus.rx_data};
   assign cnt_inc   = 17'(cnt) + 17'd1;
   assign last_word = (cnt_inc >= {1'b0, len});

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.rx_valid) begin
         unique case (state)
            IDLE, RUN, ERR: if (bus.rx_data == SYNC_BYTE) state_nxt = LEN_H;
            LEN_H: state_nxt = LEN_L;
            LEN_L: begin
               if (len_new == 16'd0 || {1'b0, len_new} > MAX_LEN) state_nxt = ERR;
               else                                                state_nxt = W_HI;
            end
            W_HI: state_nxt = W_LO;
            W_LO: begin
               if (!last_word) state_nxt = W_HI;
`ifdef LOADER_CHECKSUM_EN
               else            state_nxt = CSUM;
`else
               else            state_nxt = RUN;
`endif
            end
            CSUM: begin
               if (bus.rx_data == csum) state_nxt = RUN;
               else                     state_nxt = ERR;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Status flags are decoded from the upcoming state so they register in step with it.
   always_comb begin
      loading_d  = 1'b0;
      done_d     = 1'b0;
      error_d    = 1'b0;
      cpu_rstn_d = 1'b0;
      unique case (state_nxt)
         LEN_H, LEN_L, W_HI, W_LO, CSUM: loading_d = 1'b1;
         RUN: begin
            done_d     = 1'b1;
            cpu_rstn_d = 1'b1;
         end
         ERR:     error_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr_q <= '0;
         mem_data_q <= '0;
         mem_wr_q   <= 1'b0;
         cpu_rstn_q <= 1'b0;
         loading_q  <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         len_hi     <= '0;
         len        <= '0;
         hi_byte    <= '0;
         cnt        <= '0;
         csum       <= '0;
      end else begin
         mem_wr_q   <= 1'b0;
         cpu_rstn_q <= cpu_rstn_d;
         loading_q  <= loading_d;
         done_q     <= done_d;
         error_q    <= error_d;
         if (bus.rx_valid) begin
            unique case (state)
               LEN_H: len_hi <= bus.rx_data;
               LEN_L: begin
                  len  <= len_new;
                  cnt  <= '0;
                  csum <= '0;
               end
               W_HI: begin
                  hi_byte <= bus.rx_data;
                  csum    <= csum + bus.rx_data;
               end
               // Counter wraps to 0 after a full 2**ADDRW frame; LEN_L re-clears it anyway.
               W_LO: begin
                  mem_wr_q   <= 1'b1;
                  mem_addr_q <= cnt;
                  mem_data_q <= {hi_byte[HIW-1:0], bus.rx_data};
                  cnt        <= cnt + 1'b1;
                  csum       <= csum + bus.rx_data;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_data = mem_data_q;
   assign bus.mem_wr   = mem_wr_q;
   assign bus.cpu_rstn = cpu_rstn_q;
   assign bus.loading  = loading_q;
   assign bus.done     = done_q;
   assign bus.error    = error_q;
endmodule

// File: tb/tb_simplez_loader.sv
// Randomized bench for simplez_loader: frames are parsed by a byte-level model and
// the captured memory writes and status flags are compared against it.
module tb_simplez_loader;
   localparam int         DATAW = 12;
   localparam int         ADDRW = 9;
   localparam logic [7:0] SYNC  = 8'hA5;

   typedef struct packed {
      logic [ADDRW-1:0] a;
      logic [DATAW-1:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [7:0] frame_q[$];
   wr_t        obs_q[$];
   wr_t        exp_q[$];

   simplez_loader_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus ();

   simplez_loader #(.DATAW(DATAW), .ADDRW(ADDRW), .SYNC_BYTE(SYNC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (bus.mem_wr === 1'b1) obs_q.push_back({bus.mem_addr, bus.mem_data});

   // Reference: skip to the sync byte, read LEN, collect words, judge the checksum.
   task automatic model_frame(output bit e_done, output bit e_err, output int sidx);
      int          i;
      logic [15:0] len;
      logic [15:0] hl;
      logic [7:0]  sum;
      exp_q.delete();
      e_done = 1'b0;
      e_err  = 1'b0;
      i      = 0;
      sum    = 8'd0;
      while (i < frame_q.size() && frame_q[i] !== SYNC) i++;
      sidx = i;
      len  = {frame_q[i+1], frame_q[i+2]};
      i   += 3;
      if (len == 0 || int'(len) > (1 << ADDRW)) begin
         e_err = 1'b1;
         return;
      end
      for (int w = 0; w < int'(len); w++) begin
         hl  = {frame_q[i], frame_q[i+1]};
         sum = sum + frame_q[i] + frame_q[i+1];
         exp_q.push_back({ADDRW'(w), hl[DATAW-1:0]});
         i += 2;
      end
`ifdef LOADER_CHECKSUM_EN
      if (frame_q[i] == sum) e_done = 1'b1;
      else                   e_err  = 1'b1;
`else
      e_done = 1'b1;
`endif
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Words are random bytes, so SYNC may appear as data; bad_csum corrupts the trailer.
   task automatic build_frame(input int len, input bit bad_csum);
      logic [7:0] b;
      logic [7:0] sum;
      sum = 8'd0;
      frame_q.push_back(SYNC);
      frame_q.push_back(8'(len >> 8));
      frame_q.push_back(8'(len));
      for (int k = 0; k < 2 * len; k++) begin
         b   = 8'($urandom);
         sum = sum + b;
         frame_q.push_back(b);
      end
`ifdef LOADER_CHECKSUM_EN
      frame_q.push_back(bad_csum ? sum ^ 8'h5A : sum);
`else
      if (bad_csum) frame_q.push_back(8'h00);
`endif
   endtask

   task automatic run_frame(input string name, input int gap_max, input bit chk_drop);
      bit e_done, e_err;
      int sidx, n;
      model_frame(e_done, e_err, sidx);
      obs_q.delete();
      foreach (frame_q[k]) begin
         send_byte(frame_q[k]);
         if (chk_drop && k == sidx) begin
            n_checks++;
            if (bus.cpu_rstn !== 1'b0 || bus.loading !== 1'b1) begin
               n_fail++;
               $display("FAIL %s sync: cpu_rstn=%b loading=%b, required 0/1", name, bus.cpu_rstn, bus.loading);
            end
         end
         idle_cycles($urandom_range(gap_max, 0));
      end
      idle_cycles(4);
      n_checks++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL %s writes: got %0d, required %0d", name, obs_q.size(), exp_q.size());
      end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int k = 0; k < n; k++) begin
         n_checks++;
         if (obs_q[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL %s wr%0d: got a=%h d=%h, required a=%h d=%h",
                     name, k, obs_q[k].a, obs_q[k].d, exp_q[k].a, exp_q[k].d);
         end
      end
      n_checks++;
      if (bus.done !== e_done || bus.error !== e_err || bus.cpu_rstn !== e_done || bus.loading !== 1'b0) begin
         n_fail++;
         $display("FAIL %s status: done=%b error=%b cpu_rstn=%b loading=%b, required %b/%b/%b/0",
                  name, bus.done, bus.error, bus.cpu_rstn, bus.loading, e_done, e_err, e_done);
      end
   endtask

   task automatic check_reset_vals(input string name);
      n_checks++;
      if (bus.mem_addr !== '0 || bus.mem_data !== '0 || bus.mem_wr !== 1'b0 || bus.cpu_rstn !== 1'b0 ||
          bus.loading !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: addr=%h data=%h wr=%b rstn=%b ld=%b done=%b err=%b, required all 0",
                  name, bus.mem_addr, bus.mem_data, bus.mem_wr, bus.cpu_rstn, bus.loading, bus.done, bus.error);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_cycles(2);
      rst = 1'b0;
      check_reset_vals("reset");
   endtask

   task automatic test_basic();
      frame_q = {SYNC, 8'h00, 8'h02, 8'h0F, 8'h0F, 8'h02, 8'h00};
`ifdef LOADER_CHECKSUM_EN
      frame_q.push_back(8'h20);
`endif
      run_frame("basic", 0, 1'b0);
      n_checks++;
      if (obs_q.size() != 2 || obs_q[0] !== {9'd0, 12'hF0F} || obs_q[1] !== {9'd1, 12'h200}) begin
         n_fail++;
         $display("FAIL basic literal: got %0d writes, required 000:f0f 001:200", obs_q.size());
      end
   endtask

   task automatic test_garbage();
      frame_q = {8'h3C, 8'h11, SYNC, 8'h00, 8'h01, 8'h01, 8'h23};
`ifdef LOADER_CHECKSUM_EN
      frame_q.push_back(8'h24);
`endif
      run_frame("garbage", 2, 1'b0);
   endtask

   task automatic test_bad_len();
      frame_q = {SYNC, 8'h00, 8'h00};
      run_frame("len0", 1, 1'b0);
      frame_q = {SYNC, 8'h02, 8'h01};
      run_frame("len513", 1, 1'b0);
   endtask

   task automatic test_csum();
      frame_q = {SYNC, 8'h00, 8'h01, 8'h01, 8'h23, 8'h00};
      run_frame("csum", 1, 1'b0);
   endtask

   task automatic test_rerun();
      frame_q.delete();
      build_frame(3, 1'b0);
      run_frame("pre_run", 1, 1'b0);
      frame_q = {SYNC, 8'h00, 8'h01, 8'h00, 8'h07};
`ifdef LOADER_CHECKSUM_EN
      frame_q.push_back(8'h07);
`endif
      run_frame("rerun", 0, 1'b1);
   endtask

   task automatic test_reset_midframe();
      obs_q.delete();
      send_byte(SYNC);
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h0F);
      rst = 1'b1;
      idle_cycles(1);
      rst = 1'b0;
      idle_cycles(1);
      check_reset_vals("mid_rst");
      n_checks++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL mid_rst writes: got %0d, required 0", obs_q.size());
      end
      frame_q.delete();
      build_frame(2, 1'b0);
      run_frame("after_rst", 1, 1'b0);
   endtask

   task automatic test_random();
      for (int it = 0; it < 20; it++) begin
         frame_q.delete();
         repeat ($urandom_range(2, 0)) frame_q.push_back(8'($urandom_range(8'hA4, 0)));
         build_frame($urandom_range(8, 1), ($urandom_range(3, 0) == 0));
         run_frame($sformatf("rand%0d", it), 2, 1'b0);
      end
   endtask

   task automatic test_max_len();
      frame_q.delete();
      build_frame(1 << ADDRW, 1'b0);
      run_frame("max_len", 0, 1'b0);
   endtask

   initial begin
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_garbage();
      test_bad_len();
      test_csum();
      test_rerun();
      test_reset_midframe();
      test_random();
      test_max_len();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
